// File: rtl/match4_pkg.sv
// ----------------------------------------------------------------------------
// match4_pkg
// Shared definitions for the match_4 majority voter:
//   - synchronizer depth default and legal limits
//   - count_t: 2-bit count of asserted voters (0..3)
//   - helper functions for the vote, count and unanimity
// ----------------------------------------------------------------------------
package match4_pkg;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned SYNC_STAGES_MIN     = 2;
    localparam int unsigned SYNC_STAGES_MAX     = 4;

    typedef logic [1:0] count_t;

    // Sum of three single-bit voters; 2 bits is enough because the maximum is 3.
    function automatic count_t count3(input logic a, input logic b, input logic c);
        return count_t'({1'b0, a}) + count_t'({1'b0, b}) + count_t'({1'b0, c});
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic unanimous3(input logic a, input logic b, input logic c);
        return (a & b & c) | (~a & ~b & ~c);
    endfunction

endpackage

// File: rtl/match_4_sync.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Single-bit synchronizer chain, STAGES flops deep, asynchronous active-high
// reset to 0.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears the whole chain
//   d    - asynchronous input bit
//   q    - synchronized output (last stage of the chain)
// ----------------------------------------------------------------------------
module sync_2ff
    import match4_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $fatal(1, "sync_2ff: STAGES=%0d outside legal range", STAGES);
        end
    endgenerate

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/match_4.sv
// ----------------------------------------------------------------------------
// match_4
// Three-input majority voter with synchronized inputs and registered outputs.
// Parameters:
//   SYNC_STAGES - depth of each input synchronizer (2..4)
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset, clears every flop
//   A,B,C - voter inputs, asynchronous to clk
//   Y     - registered majority (>=2 synchronized voters high)
//   ONES  - registered count of high synchronized voters (0..3)
//   UNAN  - registered: all three synchronized voters equal
//   CHG   - one-cycle pulse on each change of Y
// ----------------------------------------------------------------------------
module match_4
    import match4_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic       Y,
    output logic [1:0] ONES,
    output logic       UNAN,
    output logic       CHG
);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $fatal(1, "match_4: SYNC_STAGES=%0d outside legal range 2..4", SYNC_STAGES);
        end
    endgenerate

    logic   a;
    logic   b;
    logic   c;
    logic   y_next;
    count_t ones_next;
    logic   unan_next;
    logic   chg_next;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst(rst), .d(A), .q(a));
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst(rst), .d(B), .q(b));
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_c (.clk(clk), .rst(rst), .d(C), .q(c));

    always_comb begin
        y_next    = majority3(a, b, c);
        ones_next = count3(a, b, c);
        unan_next = unanimous3(a, b, c);
        // Compared against the registered Y, so CHG rises in the same cycle
        // as the new Y value and lasts one cycle.
        chg_next  = y_next ^ Y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y    <= 1'b0;
            ONES <= '0;
            UNAN <= 1'b0;
            CHG  <= 1'b0;
        end else begin
            Y    <= y_next;
            ONES <= ones_next;
            UNAN <= unan_next;
            CHG  <= chg_next;
        end
    end

endmodule

// File: tb/tb_match_4.sv
// ----------------------------------------------------------------------------
// tb_match_4
// Drives two match_4 instances (SYNC_STAGES=2 and 3) from the same inputs.
// Every sampled input vector pushes its hand-tabulated outputs into a
// per-instance queue, due SYNC_STAGES edges later; a monitor pops and
// compares on each falling edge.
// ----------------------------------------------------------------------------
module tb_match_4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       C = 1'b0;
    logic       y2, y3, unan2, unan3, chg2, chg3;
    logic [1:0] ones2, ones3;

    match_4 #(.SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .Y(y2), .ONES(ones2), .UNAN(unan2), .CHG(chg2)
    );

    match_4 #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .Y(y3), .ONES(ones3), .UNAN(unan3), .CHG(chg3)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n = edge_n + 1;

    // Hand-computed truth table, indexed by {a,b,c}.
    int exp_y    [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    int exp_ones [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
    int exp_unan [8] = '{1, 0, 0, 0, 0, 0, 0, 1};

    typedef struct {
        int due;
        int y;
        int ones;
        int unan;
        int chg;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];
    int   ylast2 = 0;
    int   ylast3 = 0;
    int   cur = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", nm, act, exp, edge_n, $time);
        end
    endtask

    // Asynchronous-reset checks: everything must read 0 right now.
    task automatic chk_zero(input string tag);
        check($sformatf("%s_y_ss2", tag), int'(y2), 0);
        check($sformatf("%s_ones_ss2", tag), int'(ones2), 0);
        check($sformatf("%s_unan_ss2", tag), int'(unan2), 0);
        check($sformatf("%s_chg_ss2", tag), int'(chg2), 0);
        check($sformatf("%s_y_ss3", tag), int'(y3), 0);
        check($sformatf("%s_ones_ss3", tag), int'(ones3), 0);
        check($sformatf("%s_unan_ss3", tag), int'(unan3), 0);
        check($sformatf("%s_chg_ss3", tag), int'(chg3), 0);
    endtask

    // Set inputs (called at posedge+1, drives at posedge+2).
    task automatic drive(input int v);
        logic [2:0] bits;
        #1;
        bits = v[2:0];
        A = bits[2];
        B = bits[1];
        C = bits[0];
        cur = v;
    endtask

    // Wait for one edge; the vector present at that edge is due at the
    // outputs SYNC_STAGES edges later.
    task automatic tick();
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        k = edge_n;
        e.y    = exp_y[cur];
        e.ones = exp_ones[cur];
        e.unan = exp_unan[cur];
        e.due  = k + 2;
        e.chg  = e.y ^ ylast2;
        ylast2 = e.y;
        q2.push_back(e);
        e.due  = k + 3;
        e.chg  = e.y ^ ylast3;
        ylast3 = e.y;
        q3.push_back(e);
    endtask

    // Release reset between edges; the outputs for the first SYNC_STAGES
    // edges come from the cleared synchronizers (code 000).
    task automatic release_rst();
        exp_t e;
        int   k;
        k = edge_n;
        e.y = 0; e.ones = 0; e.unan = 1; e.chg = 0;
        for (int i = 1; i <= 2; i++) begin
            e.due = k + i;
            q2.push_back(e);
        end
        for (int i = 1; i <= 3; i++) begin
            e.due = k + i;
            q3.push_back(e);
        end
        ylast2 = 0;
        ylast3 = 0;
        #1;
        rst = 1'b0;
    endtask

    task automatic apply(input int v, input int hold);
        drive(v);
        for (int i = 0; i < hold; i++) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q2.size() != 0 || q3.size() != 0); i++) @(negedge clk);
        if (q2.size() != 0 || q3.size() != 0) begin
            check("drain_pending", q2.size() + q3.size(), 0);
        end
    endtask

    // Monitor: compare every entry that falls due at this edge.
    always @(negedge clk) begin
        exp_t e;
        while (q2.size() != 0 && q2[0].due <= edge_n) begin
            e = q2.pop_front();
            if (e.due < edge_n) begin
                check("ss2_stale_entry", edge_n, e.due);
            end else begin
                check("ss2_y", int'(y2), e.y);
                check("ss2_ones", int'(ones2), e.ones);
                check("ss2_unan", int'(unan2), e.unan);
                check("ss2_chg", int'(chg2), e.chg);
            end
        end
        while (q3.size() != 0 && q3[0].due <= edge_n) begin
            e = q3.pop_front();
            if (e.due < edge_n) begin
                check("ss3_stale_entry", edge_n, e.due);
            end else begin
                check("ss3_y", int'(y3), e.y);
                check("ss3_ones", int'(ones3), e.ones);
                check("ss3_unan", int'(unan3), e.unan);
                check("ss3_chg", int'(chg3), e.chg);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    int walk [13] = '{0, 4, 6, 2, 3, 7, 5, 1, 4, 6, 7, 0, 7};

    initial begin
        // Let outputs go non-zero (Y=1 from 111), then reset asynchronously.
        A = 1'b1; B = 1'b1; C = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst_hold");

        // Release with inputs 000.
        @(posedge clk);
        #1;
        A = 1'b0; B = 1'b0; C = 1'b0;
        cur = 0;
        release_rst();

        // Truth-table walk, CHG on 100->110 and none on 110->111,
        // then a 000->111 step for latency.
        foreach (walk[i]) apply(walk[i], (i == 12) ? 5 : 4);

        // One-cycle glitch on A while B=1, C=0.
        apply(2, 4);
        apply(6, 1);
        apply(2, 5);

        // Mid-run reset with Y=1.
        apply(7, 5);
        drain();
        @(posedge clk);
        #1;
        #1;
        rst = 1'b1;
        #1;
        chk_zero("midrst_async");
        release_rst();
        apply(7, 6);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
